// File: rtl/irq_ctrl_pkg.sv
// Shared constants, register map and FSM state type for interrupt_controller.
package irq_ctrl_pkg;

    localparam logic [2:0] REG_PENDING = 3'd0;
    localparam logic [2:0] REG_MASK    = 3'd1;
    localparam logic [2:0] REG_EDGE    = 3'd2;
    localparam logic [2:0] REG_AUTOVEC = 3'd3;
    localparam logic [2:0] REG_VBASE   = 3'd4;
    localparam logic [2:0] REG_RSVD    = 3'd5;
    localparam logic [2:0] REG_TIMER_L = 3'd6;
    localparam logic [2:0] REG_TIMER_H = 3'd7;

    localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;
    localparam logic [7:0] VBASE_RESET     = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REG_ACK,
        ST_IACK_ACK,
        ST_WAIT_AS
    } state_t;

    // Byte mask with one bit set per implemented source.
    function automatic logic [7:0] irq_bit_mask(input int n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// 68000-side bus of the interrupt controller: strobes, register window, IACK response and IPL.
interface interrupt_controller_if;
    logic       CS_n;
    logic       AS_n;
    logic       LDS_n;
    logic       RW;
    logic [2:0] FC;
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic [2:0] IPL_n;
    logic       DTACK_n;
    logic       VPA_n;

    // Handshake: the CPU opens a cycle by pulling AS_n low; the slave answers with DTACK_n
    // or VPA_n one clock later, holds it while AS_n stays low, and releases it one clock
    // after AS_n rises. A cycle is accepted once; AS_n must go high before the next one.
    modport master (
        output CS_n, AS_n, LDS_n, RW, FC, ADDR, DATA_IN,
        input  DATA_OUT, DATA_OE, IPL_n, DTACK_n, VPA_n
    );

    modport slave (
        input  CS_n, AS_n, LDS_n, RW, FC, ADDR, DATA_IN,
        output DATA_OUT, DATA_OE, IPL_n, DTACK_n, VPA_n
    );
endinterface

// File: rtl/irq_priority_select.sv
// Combinational priority pick: highest level among active sources, and the lowest-index
// active source whose level matches the acknowledged level.
module irq_priority_select #(
    parameter int          NUM_IRQ = 8,
    parameter logic [23:0] LEVELS  = 24'o76543210
) (
    input  logic [NUM_IRQ-1:0] active,
    input  logic [2:0]         iack_level,
    output logic [2:0]         max_level,
    output logic [2:0]         win_idx,
    output logic               win_valid
);

    logic [2:0] lvl;

    always_comb begin
        max_level = 3'd0;
        win_idx   = 3'd0;
        win_valid = 1'b0;
        lvl       = 3'd0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            lvl = LEVELS[3*i +: 3];
            if (active[i] && (lvl != 3'd0) && (lvl == iack_level)) begin
                win_idx   = 3'(i);
                win_valid = 1'b1;
            end
            if (active[i] && (lvl > max_level)) begin
                max_level = lvl;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// 68000 interrupt controller: latches, masks and prioritises up to 8 sources onto IPL_n
// and answers IACK cycles. Define IRQ_CTRL_TIMER_EN to turn source 0 into a periodic timer.
module interrupt_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ        = 8,
    parameter logic [23:0] LEVELS         = 24'o76543210,
    parameter int          TIMER_PRESCALE = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_IRQ-1:0]    IRQ_IN,
    interrupt_controller_if.slave bus,
    output state_t                fsm_state
);

    localparam logic [7:0] IMPL = irq_bit_mask(NUM_IRQ);

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync3_q;
    logic [7:0] pending_q, mask_q, edge_q, autovec_q, vbase_q;
    logic [7:0] sync_w, rise_w, edge_eff, set_vec, clear_vec;
    logic [7:0] pending_nxt, pending_view, active, ipl_active;
    logic [7:0] rd_data, iack_vector, data_q, timer_l_rd, timer_h_rd;
    logic [2:0] ipl_q, ipl_level, iack_max, win_idx, ipl_win_idx;
    logic       win_valid, ipl_win_valid, iack_auto;
    logic       oe_q, vpa_q, timer_fire;
    logic       reg_sel, iack_cyc, take_reg, take_iack, wr_en;
    logic       dtack, vpa, oe;

    assign sync_w = 8'(sync2_q);
    assign rise_w = 8'(sync2_q & ~sync3_q);

`ifdef IRQ_CTRL_TIMER_EN
    localparam logic [15:0] PRE_LAST = 16'(TIMER_PRESCALE - 1);

    logic [15:0] reload_q, count_q, pre_q, reload_wr;
    logic        timer_wr, tick;
    logic        unused_rise0;

    assign timer_wr   = wr_en && ((bus.ADDR == REG_TIMER_L) || (bus.ADDR == REG_TIMER_H));
    assign reload_wr  = (bus.ADDR == REG_TIMER_H) ? {bus.DATA_IN, reload_q[7:0]}
                                                  : {reload_q[15:8], bus.DATA_IN};
    assign tick       = (pre_q == PRE_LAST);
    // The counter sits at 0 for one tick before reloading, so the period is (reload+1) ticks.
    assign timer_fire = tick && !timer_wr && (reload_q != 16'd0) && (count_q == 16'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            reload_q <= '0;
            count_q  <= '0;
            pre_q    <= '0;
        end else if (timer_wr) begin
            reload_q <= reload_wr;
            count_q  <= reload_wr;
            pre_q    <= '0;
        end else if (tick) begin
            pre_q <= '0;
            if (count_q == 16'd0) count_q <= reload_q;
            else                  count_q <= count_q - 16'd1;
        end else begin
            pre_q <= pre_q + 16'd1;
        end
    end

    assign edge_eff     = edge_q | 8'h01;
    assign set_vec      = {rise_w[7:1], timer_fire};
    assign timer_l_rd   = reload_q[7:0];
    assign timer_h_rd   = reload_q[15:8];
    assign unused_rise0 = rise_w[0];
`else
    logic [31:0] unused_prescale;

    assign edge_eff        = edge_q;
    assign set_vec         = rise_w;
    assign timer_fire      = 1'b0;
    assign timer_l_rd      = 8'h00;
    assign timer_h_rd      = 8'h00;
    assign unused_prescale = 32'(TIMER_PRESCALE);
`endif

    // Level sources read straight from the synchroniser; edge sources from the latch.
    assign pending_view = ((pending_q & edge_eff) | (sync_w & ~edge_eff)) & IMPL;
    assign active       = pending_view & mask_q;
    assign pending_nxt  = ((pending_q & ~clear_vec) | set_vec) & edge_eff & IMPL;
    assign ipl_active   = (pending_nxt | (sync_w & ~edge_eff)) & mask_q & IMPL;

    assign reg_sel   = !bus.CS_n && !bus.AS_n && !bus.LDS_n && (bus.FC != 3'b111);
    assign iack_cyc  = (bus.FC == 3'b111) && !bus.AS_n;
    assign take_reg  = (state_q == ST_IDLE) && reg_sel;
    assign take_iack = (state_q == ST_IDLE) && iack_cyc;
    assign wr_en     = take_reg && !bus.RW;

    assign clear_vec = ((wr_en && (bus.ADDR == REG_PENDING)) ? bus.DATA_IN : 8'h00)
                     | ((take_iack && win_valid) ? (8'h01 << win_idx) : 8'h00);

    irq_priority_select #(.NUM_IRQ(NUM_IRQ), .LEVELS(LEVELS)) u_ipl_sel (
        .active     (ipl_active[NUM_IRQ-1:0]),
        .iack_level (3'd0),
        .max_level  (ipl_level),
        .win_idx    (ipl_win_idx),
        .win_valid  (ipl_win_valid)
    );

    irq_priority_select #(.NUM_IRQ(NUM_IRQ), .LEVELS(LEVELS)) u_iack_sel (
        .active     (active[NUM_IRQ-1:0]),
        .iack_level (bus.ADDR),
        .max_level  (iack_max),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    logic unused_sel;
    assign unused_sel = ^{ipl_win_idx, ipl_win_valid, iack_max};

    assign iack_auto   = win_valid && autovec_q[win_idx];
    assign iack_vector = win_valid ? (vbase_q + {5'b0, win_idx}) : SPURIOUS_VECTOR;

    always_comb begin
        rd_data = 8'h00;
        case (bus.ADDR)
            REG_PENDING: rd_data = pending_view;
            REG_MASK:    rd_data = mask_q;
            REG_EDGE:    rd_data = edge_q;
            REG_AUTOVEC: rd_data = autovec_q;
            REG_VBASE:   rd_data = vbase_q;
            REG_RSVD:    rd_data = 8'h00;
            REG_TIMER_L: rd_data = timer_l_rd;
            REG_TIMER_H: rd_data = timer_h_rd;
            default:     rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            autovec_q <= IMPL;
            vbase_q   <= VBASE_RESET;
            ipl_q     <= 3'b111;
            data_q    <= '0;
            oe_q      <= 1'b0;
            vpa_q     <= 1'b0;
        end else begin
            sync1_q   <= IRQ_IN;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_nxt;
            ipl_q     <= ~ipl_level;
            if (wr_en) begin
                case (bus.ADDR)
                    REG_MASK:    mask_q    <= bus.DATA_IN & IMPL;
                    REG_EDGE:    edge_q    <= bus.DATA_IN & IMPL;
                    REG_AUTOVEC: autovec_q <= bus.DATA_IN & IMPL;
                    REG_VBASE:   vbase_q   <= bus.DATA_IN;
                    default:     ;
                endcase
            end
            if (take_reg) begin
                data_q <= bus.RW ? rd_data : 8'h00;
                oe_q   <= bus.RW;
                vpa_q  <= 1'b0;
            end else if (take_iack) begin
                data_q <= iack_auto ? 8'h00 : iack_vector;
                oe_q   <= !iack_auto;
                vpa_q  <= iack_auto;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dtack   = 1'b0;
        vpa     = 1'b0;
        oe      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reg_sel)       state_d = ST_REG_ACK;
                else if (iack_cyc) state_d = ST_IACK_ACK;
            end
            ST_REG_ACK: begin
                dtack = 1'b1;
                oe    = oe_q;
                if (bus.AS_n) state_d = ST_WAIT_AS;
            end
            ST_IACK_ACK: begin
                dtack = !vpa_q;
                vpa   = vpa_q;
                oe    = oe_q;
                if (bus.AS_n) state_d = ST_WAIT_AS;
            end
            ST_WAIT_AS: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign bus.DTACK_n  = !dtack;
    assign bus.VPA_n    = !vpa;
    assign bus.DATA_OE  = oe;
    assign bus.DATA_OUT = oe ? data_q : 8'h00;
    assign bus.IPL_n    = ipl_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register access, IPL timing, IACK responses, reset.
module tb_interrupt_controller;
    import irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq;
    state_t     fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int last_lat;
    int k;

    logic [7:0] rd;
    logic [7:0] iack_data;
    logic       iack_oe, iack_dtack, iack_vpa, iack_hold;
    logic       vpa_low_seen, dtack_low_seen;
    logic [2:0] iack_rel;
    int         iack_lat;

    interrupt_controller_if bus();

    interrupt_controller #(
        .NUM_IRQ(8), .LEVELS(24'o76543210), .TIMER_PRESCALE(4)
    ) dut (
        .CLK(clk), .RST(rst), .IRQ_IN(irq), .bus(bus), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.CS_n = 1'b1; bus.AS_n = 1'b1; bus.LDS_n = 1'b1; bus.RW = 1'b1;
        bus.FC = 3'b000; bus.ADDR = 3'd0; bus.DATA_IN = 8'h00;
    endtask

    task automatic reg_access(input logic [2:0] a, input logic rw, input logic [7:0] d,
                              output logic [7:0] q);
        int n;
        step(1);
        bus.CS_n = 1'b0; bus.AS_n = 1'b0; bus.LDS_n = 1'b0; bus.RW = rw;
        bus.FC = 3'b101; bus.ADDR = a; bus.DATA_IN = d;
        n = 0;
        do begin step(1); n++; end while (bus.DTACK_n !== 1'b0 && n < 6);
        last_lat = n;
        q = bus.DATA_OUT;
        check("reg_dtack", 16'(bus.DTACK_n), 16'h0);
        bus_idle();
        step(1);
        check("reg_release", 16'(bus.DTACK_n), 16'h1);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        reg_access(a, 1'b0, d, dummy);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] q);
        reg_access(a, 1'b1, 8'h00, q);
    endtask

    task automatic do_iack(input logic [2:0] lvl);
        int n;
        step(1);
        bus.FC = 3'b111; bus.ADDR = lvl; bus.LDS_n = 1'b0; bus.AS_n = 1'b0;
        vpa_low_seen = 1'b0; dtack_low_seen = 1'b0;
        n = 0;
        do begin
            step(1); n++;
            if (bus.VPA_n !== 1'b1) vpa_low_seen = 1'b1;
            if (bus.DTACK_n !== 1'b1) dtack_low_seen = 1'b1;
        end while (bus.DTACK_n !== 1'b0 && bus.VPA_n !== 1'b0 && n < 6);
        iack_lat = n; iack_data = bus.DATA_OUT; iack_oe = bus.DATA_OE;
        iack_dtack = bus.DTACK_n; iack_vpa = bus.VPA_n;
        step(1);
        iack_hold = (bus.DTACK_n === iack_dtack) && (bus.VPA_n === iack_vpa);
        if (bus.VPA_n !== 1'b1) vpa_low_seen = 1'b1;
        if (bus.DTACK_n !== 1'b1) dtack_low_seen = 1'b1;
        bus_idle();
        step(1);
        iack_rel = {bus.DTACK_n, bus.VPA_n, bus.DATA_OE};
    endtask

    task automatic pulse(input int i);
        step(1);
        irq[i] = 1'b1;
        step(2);
        irq[i] = 1'b0;
        step(3);
    endtask

    initial begin
        rst = 1'b1; irq = 8'h00; bus_idle();
        step(3);
        check("rst_ipl", 16'(bus.IPL_n), 16'h7);
        check("rst_dtack", 16'(bus.DTACK_n), 16'h1);
        check("rst_vpa", 16'(bus.VPA_n), 16'h1);
        check("rst_oe", 16'(bus.DATA_OE), 16'h0);
        check("rst_dout", 16'(bus.DATA_OUT), 16'h0);
        check("rst_state", 16'(fsm_state), 16'(ST_IDLE));
        rst = 1'b0;

        bus_read(REG_PENDING, rd); check("rst_pending", 16'(rd), 16'h00);
        bus_read(REG_MASK, rd);    check("rst_mask", 16'(rd), 16'h00);
        bus_read(REG_EDGE, rd);    check("rst_edge", 16'(rd), 16'h00);
        bus_read(REG_AUTOVEC, rd); check("rst_autovec", 16'(rd), 16'hFF);
        bus_read(REG_VBASE, rd);   check("rst_vbase", 16'(rd), 16'h40);
        bus_read(REG_RSVD, rd);    check("rsvd_zero", 16'(rd), 16'h00);
        bus_read(REG_TIMER_L, rd); check("rst_timer_l", 16'(rd), 16'h00);

        bus_write(REG_MASK, 8'h06);
        check("wr_latency", 16'(last_lat), 16'd1);
        bus_write(REG_EDGE, 8'h06);
        bus_read(REG_MASK, rd); check("mask_rb", 16'(rd), 16'h06);
        bus_read(REG_EDGE, rd); check("edge_rb", 16'(rd), 16'h06);

        // IRQ_IN[2] rise: IPL_n must change exactly at the third edge.
        step(1); irq[2] = 1'b1;
        step(2); check("ipl_2_early", 16'(bus.IPL_n), 16'h7);
        irq[2] = 1'b0;
        step(1); check("ipl_2_at3", 16'(bus.IPL_n), 16'h5);
        pulse(1);
        check("ipl_1_lower", 16'(bus.IPL_n), 16'h5);
        bus_read(REG_PENDING, rd); check("pend_21", 16'(rd), 16'h06);

        bus_write(REG_PENDING, 8'h04);
        bus_read(REG_PENDING, rd); check("w1c_2", 16'(rd), 16'h02);
        check("ipl_after_w1c", 16'(bus.IPL_n), 16'h6);
        bus_write(REG_PENDING, 8'h02);
        bus_read(REG_PENDING, rd); check("w1c_1", 16'(rd), 16'h00);
        check("ipl_none", 16'(bus.IPL_n), 16'h7);

        // Vectored IACK for source 5.
        bus_write(REG_EDGE, 8'h26);
        bus_write(REG_MASK, 8'h26);
        bus_write(REG_AUTOVEC, 8'h00);
        pulse(5);
        check("ipl_5", 16'(bus.IPL_n), 16'h2);
        do_iack(3'd5);
        check("iack5_lat", 16'(iack_lat), 16'd1);
        check("iack5_data", 16'(iack_data), 16'h45);
        check("iack5_oe", 16'(iack_oe), 16'h1);
        check("iack5_dtack", 16'(iack_dtack), 16'h0);
        check("iack5_vpa_high", 16'(vpa_low_seen), 16'h0);
        check("iack5_hold", 16'(iack_hold), 16'h1);
        check("iack5_release", 16'(iack_rel), 16'b110);
        bus_read(REG_PENDING, rd); check("iack5_cleared", 16'(rd), 16'h00);
        check("ipl_after_iack5", 16'(bus.IPL_n), 16'h7);

        do_iack(3'd3);
        check("spur_data", 16'(iack_data), 16'h18);
        check("spur_dtack", 16'(iack_dtack), 16'h0);
        check("spur_vpa_high", 16'(vpa_low_seen), 16'h0);

        // Autovectored source 3.
        bus_write(REG_EDGE, 8'h2E);
        bus_write(REG_MASK, 8'h2E);
        bus_write(REG_AUTOVEC, 8'h08);
        pulse(3);
        check("ipl_3", 16'(bus.IPL_n), 16'h4);
        do_iack(3'd3);
        check("auto3_lat", 16'(iack_lat), 16'd1);
        check("auto3_vpa", 16'(iack_vpa), 16'h0);
        check("auto3_dtack_high", 16'(dtack_low_seen), 16'h0);
        check("auto3_oe", 16'(iack_oe), 16'h0);
        check("auto3_release", 16'(iack_rel), 16'b110);
        bus_read(REG_PENDING, rd); check("auto3_cleared", 16'(rd), 16'h00);

        // Level-triggered source 4 ignores W1C and follows the input.
        bus_write(REG_MASK, 8'h3E);
        irq[4] = 1'b1;
        step(4);
        check("ipl_4", 16'(bus.IPL_n), 16'h3);
        bus_read(REG_PENDING, rd); check("lvl4_set", 16'(rd), 16'h10);
        bus_write(REG_PENDING, 8'h10);
        bus_read(REG_PENDING, rd); check("lvl4_w1c_ignored", 16'(rd), 16'h10);
        step(1); irq[4] = 1'b0;
        step(2); check("lvl4_ipl_hold", 16'(bus.IPL_n), 16'h3);
        step(1); check("lvl4_ipl_drop", 16'(bus.IPL_n), 16'h7);
        bus_read(REG_PENDING, rd); check("lvl4_clear", 16'(rd), 16'h00);

        // VBASE + index wraps at 8 bits.
        bus_write(REG_VBASE, 8'hFE);
        bus_write(REG_AUTOVEC, 8'h00);
        pulse(5);
        do_iack(3'd5);
        check("wrap_data", 16'(iack_data), 16'h03);

        // Reset in the middle of a vectored IACK.
        step(1); irq[5] = 1'b1; irq[2] = 1'b1;
        step(2); irq[5] = 1'b0; irq[2] = 1'b0;
        step(3);
        check("ipl_52", 16'(bus.IPL_n), 16'h2);
        bus.FC = 3'b111; bus.ADDR = 3'd5; bus.LDS_n = 1'b0; bus.AS_n = 1'b0;
        step(1);
        check("mid_dtack", 16'(bus.DTACK_n), 16'h0);
        check("mid_ipl", 16'(bus.IPL_n), 16'h5);
        rst = 1'b1;
        step(1);
        check("mrst_dtack", 16'(bus.DTACK_n), 16'h1);
        check("mrst_vpa", 16'(bus.VPA_n), 16'h1);
        check("mrst_oe", 16'(bus.DATA_OE), 16'h0);
        check("mrst_dout", 16'(bus.DATA_OUT), 16'h0);
        check("mrst_ipl", 16'(bus.IPL_n), 16'h7);
        bus_idle();
        step(1); rst = 1'b0;
        step(2);
        check("mrst_state", 16'(fsm_state), 16'(ST_IDLE));
        bus_read(REG_MASK, rd); check("mrst_mask", 16'(rd), 16'h00);

`ifdef IRQ_CTRL_TIMER_EN
        // Prescale 4, reload 3: first set lands 16 cycles after the committing edge.
        step(1);
        bus.CS_n = 1'b0; bus.AS_n = 1'b0; bus.LDS_n = 1'b0; bus.RW = 1'b0;
        bus.FC = 3'b101; bus.ADDR = REG_TIMER_L; bus.DATA_IN = 8'h03;
        step(1);
        bus_idle();
        k = 0;
        while (dut.pending_q[0] !== 1'b1 && k < 40) begin step(1); k++; end
        check("timer_first", 16'(k), 16'd16);
        bus_write(REG_PENDING, 8'h01);
        k = 0;
        while (dut.pending_q[0] !== 1'b1 && k < 24) begin step(1); k++; end
        check("timer_again", 16'(dut.pending_q[0]), 16'h1);
        bus_write(REG_TIMER_L, 8'h00);
        bus_write(REG_PENDING, 8'h01);
        step(40);
        check("timer_stopped", 16'(dut.pending_q[0]), 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Parametrised 68000 interrupt controller, successor to the fixed-priority IPL encoder and the hard-wired timer/autovector logic in the system controller. It latches up to 8 interrupt sources, each edge- or level-triggered, and masks and prioritises them onto IPL_n. It answers CPU IACK cycles with either VPA_n (autovector) or a programmable vector plus DTACK_n. It sits beside the address decoder: the decoder supplies CS_n for the register window, and the controller's DTACK_n and VPA_n are ANDed into the CPU's lines.

## Interface
Parameters:
- NUM_IRQ, 8: number of sources, 1..8.
- LEVELS, 24'o76543210: packed 3 bits per source giving the IPL level of source i. Level 0 means the source is never presented.
- TIMER_PRESCALE, 100: CLK cycles per timer tick (timer build only).

Ports:
- CLK  in  1  system clock (CPU clock domain).
- RST  in  1  synchronous, active-high reset.
- IRQ_IN  in  NUM_IRQ  raw active-high interrupt requests, asynchronous.
- CS_n  in  1  register window select from the decoder.
- AS_n, LDS_n, RW  in  1 each  68000 bus strobes.
- FC  in  3  function code.
- ADDR  in  3  A3..A1. Selects the register; during IACK it carries the acknowledged level.
- DATA_IN  in  8  D7..D0 write data.
- DATA_OUT  out  8  read data or vector.
- DATA_OE  out  1  drive D7..D0 enable.
- IPL_n  out  3  encoded priority to the CPU.
- DTACK_n  out  1  register or vectored-IACK acknowledge.
- VPA_n  out  1  autovector request.

## Operation
- Input path: each IRQ_IN bit passes through a 2-FF synchroniser. An edge source detects the rising edge of the synchronised value.
- PENDING:
  - Edge mode: bit is set on a detected edge. It is cleared by writing 1 to it, or by being the source acknowledged in IACK. If a set and a clear occur in the same cycle, the set wins.
  - Level mode: bit mirrors the synchronised input. Writes and IACK have no effect.
- Active set = PENDING & MASK. IPL_n is the inverse of the highest LEVELS value among active sources, and 3'b111 if none are active.
- Registers, 8-bit, on odd bytes (LDS_n), indexed by ADDR:
  - 0 PENDING (R, W1C).
  - 1 MASK (RW).
  - 2 EDGE (RW, 1 = edge-triggered).
  - 3 AUTOVEC (RW, 1 = autovector).
  - 4 VBASE (RW).
  - 5 reserved (reads 0).
  - 6 TIMER_L (RW).
  - 7 TIMER_H (RW).
  - Bits at or above NUM_IRQ read 0 and ignore writes.
- IACK cycle: FC==3'b111 and AS_n low.
  - Winner = lowest-index active source whose LEVELS value equals ADDR.
  - Winner with its AUTOVEC bit set: assert VPA_n.
  - Winner with AUTOVEC clear: drive DATA_OUT = VBASE + index (8-bit wrap), with DATA_OE and DTACK_n.
  - No winner: drive the spurious vector 8'h18 with DTACK_n.
  - An edge-mode winner's pending bit clears in the cycle the response is asserted.
- FSM states IDLE, REG_ACK, IACK_ACK, WAIT_AS.
  - IDLE -> REG_ACK on CS_n & !AS_n & !LDS_n & FC!=7.
  - IDLE -> IACK_ACK on an IACK cycle.
  - REG_ACK and IACK_ACK hold their outputs while AS_n is low, then go to WAIT_AS.
  - WAIT_AS releases all outputs and returns to IDLE.
- Each bus cycle is handled once: no re-entry until AS_n has been seen high.

## Timing
- Reset values:
  - Outputs: IPL_n=3'b111, DTACK_n=1, VPA_n=1, DATA_OE=0, DATA_OUT=0.
  - Registers: PENDING=0, MASK=0, EDGE=0, AUTOVEC=all 1, VBASE=8'h40, TIMER=0.
  - Synchronisers and the timer counter are cleared.
- IRQ_IN rise to IPL_n change: 3 CLK cycles (2 sync + 1 latch), with IPL_n registered.
- Register access:
  - Write commits at the first edge with CS_n, AS_n and LDS_n all low.
  - DTACK_n goes low 1 cycle after select and stays low until the cycle after AS_n rises.
  - Read data is valid while DTACK_n is low.
- IACK response (VPA_n or DTACK_n) asserts 1 cycle after the IACK cycle is detected and releases 1 cycle after AS_n rises.
- RST asserted mid-cycle: outputs return to reset values at the next edge, even with AS_n still low. The FSM restarts in IDLE.

## Configuration
- IRQ_CTRL_TIMER_EN defined:
  - Source 0 is an internal periodic timer and IRQ_IN[0] is ignored.
  - Every TIMER_PRESCALE CLK cycles a 16-bit down-counter decrements. On reaching 0 it reloads from {TIMER_H,TIMER_L} and sets PENDING[0].
  - Source 0 is always edge mode.
  - A reload value of 0 stops the timer.
  - Writing TIMER_H or TIMER_L reloads the counter immediately.
- IRQ_CTRL_TIMER_EN undefined: source 0 is ordinary, registers 6 and 7 read 0, and no counter logic is built.

## Structure
- Package irq_ctrl_pkg holds:
  - Register index constants.
  - The FSM state enum.
  - SPURIOUS_VECTOR=8'h18.
  - The VBASE reset constant.
- Sub-module irq_priority_select is combinational: it takes active, LEVELS and an IACK level, and returns the max level, the winner index and a winner-valid flag. It is used twice, once for IPL and once for IACK.

## Test plan
- MASK=8'h06, EDGE=8'h06, LEVELS default, pulse IRQ_IN[2] -> IPL_n=3'b101 after 3 cycles. Pulse IRQ_IN[1] as well -> IPL_n unchanged.
- AUTOVEC=0, VBASE=8'h40, source 5 pending, IACK with ADDR=5 -> DATA_OUT=8'h45, DTACK_n low, PENDING[5] cleared, VPA_n high throughout.
- IACK at level 3 with nothing active at level 3 -> DATA_OUT=8'h18 with DTACK_n. With AUTOVEC=1 on source 3 pending instead -> VPA_n low and DTACK_n high.
- Level source 4: write 1 to PENDING[4] while IRQ_IN[4] high -> bit stays 1. Drop IRQ_IN[4] -> bit clears 2 cycles later.
- Timer build, TIMER_PRESCALE=4, reload 3, MASK[0]=1 -> PENDING[0] sets every 16 cycles. Write reload 0 -> no further sets.
- Assert RST while DTACK_n is low in an IACK cycle -> next edge DTACK_n=1, DATA_OE=0, IPL_n=3'b111.
